// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake state, data word, and the
// memory arbiter's owner encoding.
package cpu_types_pkg;

    localparam int WORD_W_DEF   = 32;
    localparam int BLK_WORD_BIT = 2;

    typedef logic [WORD_W_DEF-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_OWN = 2'd1,
        D_OWN = 2'd2
    } arb_owner_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and RAM-side signal bundle of the memory arbiter.
// ARB_STATS_EN adds the grant/starvation statistics outputs.
interface cache_mem_arbiter_if #(
    parameter int WORD_W = 32
);
    import cpu_types_pkg::*;

    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic [WORD_W-1:0] iload;
    logic              iwait;
    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic [WORD_W-1:0] dload;
    logic              dwait;
    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    ramstate_t         ramstate;
`ifdef ARB_STATS_EN
    logic [WORD_W-1:0] igrant_cnt;
    logic [WORD_W-1:0] dgrant_cnt;
    logic [WORD_W-1:0] starve_evt_cnt;
`endif

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore,
        output ramload, ramstate,
        input  iload, iwait, dload, dwait,
        input  ramREN, ramWEN, ramaddr, ramstore
`ifdef ARB_STATS_EN
        , input igrant_cnt, dgrant_cnt, starve_evt_cnt
`endif
    );

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore,
        input  ramload, ramstate,
        output iload, iwait, dload, dwait,
        output ramREN, ramWEN, ramaddr, ramstore
`ifdef ARB_STATS_EN
        , output igrant_cnt, dgrant_cnt, starve_evt_cnt
`endif
    );

endinterface

// File: rtl/cache_mem_arbiter_starve_ctr.sv
// Saturating icache starvation counter; clear wins over increment.
module arb_starve_ctr #(
    parameter int SCW        = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           inc,
    input  logic           clr,
    output logic [SCW-1:0] cnt,
    output logic           sat
);

    assign sat = (cnt >= SCW'(STARVE_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Icache/dcache arbiter for the single-port RAM with dcache block lock
// and icache starvation relief. ARB_STATS_EN adds grant statistics.
module cache_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = 8,
    parameter int SCW        = 4
) (
    input logic                 CLK,
    input logic                 RST,
    cache_mem_arbiter_if.slave  bus
);

    arb_owner_t        owner, owner_nx;
    logic              ireq, dreq, done, arb_pt;
    logic              starve_sat;
    logic [SCW-1:0]    starve;
    logic              ram_ren, ram_wen, iwait, dwait;
    logic [WORD_W-1:0] ram_addr, ram_store, iload, dload;

    assign ireq   = bus.iREN;
    assign dreq   = bus.dREN | bus.dWEN;
    assign done   = (bus.ramstate == ACCESS);
    assign arb_pt = (done && bus.daddr[BLK_WORD_BIT]) || !dreq;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            owner <= IDLE;
        end else begin
            owner <= owner_nx;
        end
    end

    always_comb begin
        owner_nx  = owner;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        iload     = '0;
        dload     = '0;
        iwait     = 1'b1;
        dwait     = 1'b1;
        unique case (owner)
            IDLE: begin
                if (dreq)      owner_nx = D_OWN;
                else if (ireq) owner_nx = I_OWN;
            end
            I_OWN: begin
                ram_ren  = bus.iREN;
                ram_addr = bus.iaddr;
                iload    = bus.ramload;
                iwait    = ~done;
                if (!ireq)     owner_nx = IDLE;
                else if (done) owner_nx = dreq ? D_OWN : I_OWN;
            end
            D_OWN: begin
                // a simultaneous read+write request is a write
                ram_wen   = bus.dWEN;
                ram_ren   = bus.dREN & ~bus.dWEN;
                ram_addr  = bus.daddr;
                ram_store = bus.dstore;
                dload     = bus.ramload;
                dwait     = ~done;
                if (arb_pt) begin
                    if (ireq && starve_sat) owner_nx = I_OWN;
                    else if (dreq)          owner_nx = D_OWN;
                    else if (ireq)          owner_nx = I_OWN;
                    else                    owner_nx = IDLE;
                end
            end
            default: owner_nx = IDLE;
        endcase
    end

    arb_starve_ctr #(
        .SCW        (SCW),
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk (CLK),
        .rst (RST),
        .inc (owner == D_OWN && ireq),
        .clr (owner_nx == I_OWN),
        .cnt (starve),
        .sat (starve_sat)
    );

    assign bus.ramREN   = ram_ren;
    assign bus.ramWEN   = ram_wen;
    assign bus.ramaddr  = ram_addr;
    assign bus.ramstore = ram_store;
    assign bus.iload    = iload;
    assign bus.dload    = dload;
    assign bus.iwait    = iwait;
    assign bus.dwait    = dwait;

`ifdef ARB_STATS_EN
    logic [WORD_W-1:0] igrant_cnt, dgrant_cnt, starve_evt_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            igrant_cnt     <= '0;
            dgrant_cnt     <= '0;
            starve_evt_cnt <= '0;
        end else begin
            if (owner == I_OWN && done)
                igrant_cnt <= igrant_cnt + 1'b1;
            if (owner == D_OWN && done)
                dgrant_cnt <= dgrant_cnt + 1'b1;
            if (owner == D_OWN && arb_pt && ireq && starve_sat)
                starve_evt_cnt <= starve_evt_cnt + 1'b1;
        end
    end

    assign bus.igrant_cnt     = igrant_cnt;
    assign bus.dgrant_cnt     = dgrant_cnt;
    assign bus.starve_evt_cnt = starve_evt_cnt;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: arbitration latency, dcache
// priority and block lock, starvation relief, RAM error hold, reset.
module tb_cache_mem_arbiter;
    import cpu_types_pkg::*;

    logic CLK;
    logic RST;
    int   passed;
    int   total;

    cache_mem_arbiter_if #(.WORD_W(32)) bus ();

    cache_mem_arbiter #(
        .WORD_W     (32),
        .STARVE_MAX (8),
        .SCW        (4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        else
            passed++;
    endtask

    task automatic clear_inputs();
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramstate = FREE;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        clear_inputs();
        bus.ramload = 32'hAAAA_5555;
        bus.dstore  = 32'h1234_5678;
        tick();
        chk("rst_owner", 32'(dut.owner), 32'(IDLE));
        chk("rst_iwait", 32'(bus.iwait), 32'd1);
        chk("rst_dwait", 32'(bus.dwait), 32'd1);
        chk("rst_ramREN", 32'(bus.ramREN), 32'd0);
        chk("rst_ramstore", bus.ramstore, 32'd0);
        chk("rst_iload", bus.iload, 32'd0);
        chk("rst_starve", 32'(dut.starve), 32'd0);
        RST = 1'b0;
        bus.dstore = '0;
        tick();
    endtask

    task automatic test_icache_read();
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h40;
        bus.ramstate = BUSY;
        #1;
        chk("i_arb_latency", 32'(bus.ramREN), 32'd0);
        tick();
        chk("i_owner", 32'(dut.owner), 32'(I_OWN));
        chk("i_ramREN", 32'(bus.ramREN), 32'd1);
        chk("i_ramaddr", bus.ramaddr, 32'h40);
        chk("i_iwait_busy1", 32'(bus.iwait), 32'd1);
        tick();
        chk("i_iwait_busy2", 32'(bus.iwait), 32'd1);
        tick();
        bus.ramstate = ACCESS;
        bus.ramload  = 32'hCAFE_0040;
        #1;
        chk("i_iwait_done", 32'(bus.iwait), 32'd0);
        chk("i_iload", bus.iload, 32'hCAFE_0040);
        chk("i_dwait", 32'(bus.dwait), 32'd1);
        tick();
        bus.iREN     = 1'b0;
        bus.ramstate = FREE;
        #1;
        chk("i_iwait_after", 32'(bus.iwait), 32'd1);
        tick();
        chk("i_back_idle", 32'(dut.owner), 32'(IDLE));
    endtask

    task automatic test_dcache_priority();
        bus.ramstate = BUSY;
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h50;
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h80;
        tick();
        chk("p_owner_d", 32'(dut.owner), 32'(D_OWN));
        chk("p_ramaddr0", bus.ramaddr, 32'h80);
        chk("p_iwait", 32'(bus.iwait), 32'd1);
        bus.ramstate = ACCESS;
        bus.ramload  = 32'hD000_0080;
        #1;
        chk("p_dwait0", 32'(bus.dwait), 32'd0);
        chk("p_dload0", bus.dload, 32'hD000_0080);
        tick();
        bus.daddr   = 32'h84;
        bus.ramload = 32'hD000_0084;
        #1;
        chk("p_owner_w1", 32'(dut.owner), 32'(D_OWN));
        chk("p_ramaddr1", bus.ramaddr, 32'h84);
        chk("p_dload1", bus.dload, 32'hD000_0084);
        tick();
        bus.dREN = 1'b0;
        #1;
        chk("p_no_igrant", 32'(dut.owner), 32'(D_OWN));
        tick();
        chk("p_igrant", 32'(dut.owner), 32'(I_OWN));
        chk("p_iaddr", bus.ramaddr, 32'h50);
        bus.iREN     = 1'b0;
        bus.ramstate = FREE;
        tick();
        chk("p_idle", 32'(dut.owner), 32'(IDLE));
    endtask

    task automatic test_write_block_lock();
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h60;
        bus.dREN     = 1'b1;
        bus.dWEN     = 1'b1;
        bus.daddr    = 32'h100;
        bus.dstore   = 32'h1111_1111;
        bus.ramstate = ACCESS;
        tick();
        chk("w_ramWEN0", 32'(bus.ramWEN), 32'd1);
        chk("w_ramREN0", 32'(bus.ramREN), 32'd0);
        chk("w_ramstore0", bus.ramstore, 32'h1111_1111);
        tick();
        chk("w_lock", 32'(dut.owner), 32'(D_OWN));
        bus.daddr  = 32'h104;
        bus.dstore = 32'h2222_2222;
        #1;
        chk("w_ramWEN1", 32'(bus.ramWEN), 32'd1);
        chk("w_ramstore1", bus.ramstore, 32'h2222_2222);
        chk("w_ramaddr1", bus.ramaddr, 32'h104);
        tick();
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
        tick();
        chk("w_igrant", 32'(dut.owner), 32'(I_OWN));
        bus.iREN     = 1'b0;
        bus.ramstate = FREE;
        tick();
    endtask

    task automatic test_starvation();
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h70;
        bus.dREN     = 1'b1;
        bus.ramstate = ACCESS;
        bus.daddr    = 32'h200;
        tick();
        for (int k = 1; k <= 10; k++) begin
            bus.daddr = 32'h200 + 32'((k - 1) / 2 * 8)
                      + ((k % 2 == 0) ? 32'h4 : 32'h0);
            #1;
            chk($sformatf("s_owner_k%0d", k), 32'(dut.owner), 32'(D_OWN));
            chk($sformatf("s_cnt_k%0d", k), 32'(dut.starve),
                32'((k - 1 > 8) ? 8 : k - 1));
            tick();
        end
        chk("s_forced_igrant", 32'(dut.owner), 32'(I_OWN));
        chk("s_cnt_cleared", 32'(dut.starve), 32'd0);
        bus.dREN     = 1'b0;
        bus.iREN     = 1'b0;
        bus.ramstate = FREE;
        tick();
        chk("s_idle", 32'(dut.owner), 32'(IDLE));
    endtask

    task automatic test_ram_error();
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h304;
        bus.ramstate = ERROR;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("e_dwait_%0d", i), 32'(bus.dwait), 32'd1);
            chk($sformatf("e_owner_%0d", i), 32'(dut.owner), 32'(D_OWN));
            tick();
        end
        bus.ramstate = ACCESS;
        bus.ramload  = 32'hE000_0304;
        #1;
        chk("e_dwait_done", 32'(bus.dwait), 32'd0);
        chk("e_dload", bus.dload, 32'hE000_0304);
        tick();
        bus.dREN     = 1'b0;
        bus.ramstate = FREE;
        tick();
        chk("e_idle", 32'(dut.owner), 32'(IDLE));
    endtask

    task automatic test_reset_mid_block();
        bus.iREN     = 1'b1;
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h400;
        bus.dstore   = 32'h5A5A_5A5A;
        bus.ramload  = 32'h0BAD_F00D;
        bus.ramstate = ACCESS;
        tick();
        tick();
        bus.daddr = 32'h404;
        #1;
        chk("r_pre_cnt", 32'(dut.starve), 32'd1);
        chk("r_pre_owner", 32'(dut.owner), 32'(D_OWN));
        RST = 1'b1;
        #1;
        chk("r_owner", 32'(dut.owner), 32'(IDLE));
        chk("r_ramREN", 32'(bus.ramREN), 32'd0);
        chk("r_ramaddr", bus.ramaddr, 32'd0);
        chk("r_ramstore", bus.ramstore, 32'd0);
        chk("r_dwait", 32'(bus.dwait), 32'd1);
        chk("r_iwait", 32'(bus.iwait), 32'd1);
        chk("r_dload", bus.dload, 32'd0);
        chk("r_starve", 32'(dut.starve), 32'd0);
`ifdef ARB_STATS_EN
        chk("r_igrant_cnt", bus.igrant_cnt, 32'd0);
        chk("r_dgrant_cnt", bus.dgrant_cnt, 32'd0);
        chk("r_starve_evt_cnt", bus.starve_evt_cnt, 32'd0);
`endif
        tick();
        clear_inputs();
        RST = 1'b0;
        tick();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_icache_read();
        test_dcache_priority();
        test_write_block_lock();
        test_starvation();
        test_ram_error();
        test_reset_mid_block();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
